bird_datapath: RTL and testbench
================================

// Module: bird_datapath
// PURPOSE
//   Datapath end of the bird control interface. Executes the 3-bit state code driven by the bird control FSM.
//   Moves the bird's y position, erases and redraws the bird sprite through the 160x120 VGA adapter
//   pixel port, and returns the status signals flag (too high) and touched (hit ground) to the controller.
//   Acts once per frame_tick and ignores state codes between ticks.
// PARAMETERS
//   X_POS        40      fixed sprite column (left edge)
//   BIRD_W       4       sprite width, pixels
//   BIRD_H       4       sprite height, pixels
//   Y_START      56      y after reset, START or STOP
//   Y_MIN        4       flag=1 while bird_y < Y_MIN
//   Y_MAX        116     ground row; bird_y saturates here, touched set
//   RISE_STEP    2       y decrement per RAISING command
//   FALL_STEP    1       y increment per FALLING command
//   BIRD_COLOUR  3'b110  sprite colour
//   BG_COLOUR    3'b000  erase colour
//   Legal only if X_POS+BIRD_W<=160 and Y_MAX+BIRD_H<=120.
// PORTS
//   clk         in   1  system clock
//   resetn      in   1  asynchronous reset, active-low
//   state_in    in   3  command: START=010 RAISING=110 FALLING=011 STOP=001 DRAW=111
//   frame_tick  in   1  one-cycle pulse, ~60 Hz; permits one update
//   x_out       out  8  pixel x to VGA adapter
//   y_out       out  7  pixel y to VGA adapter
//   colour      out  3  pixel colour
//   plot        out  1  pixel write enable
//   busy        out  1  1 while an update is in progress
//   done        out  1  one-cycle pulse at end of update
//   bird_y      out  7  current bird top row
//   flag        out  1  bird too high (bird_y < Y_MIN)
//   touched     out  1  sticky: bird reached Y_MAX
// BEHAVIOUR
// - Reset
//   - resetn low, at any time and asynchronously: FSM goes to IDLE; scan counters clear.
//   - Outputs: bird_y=Y_START; plot, busy, done, touched, flag, x_out, y_out and colour are 0.
//   - Reset during a scan aborts it immediately; no partial pixels are issued after reset.
// - FSM states: IDLE -> ERASE -> UPDATE -> DRAW -> DONE -> IDLE.
// - IDLE
//   - Accept a command when frame_tick=1 and state_in is START, RAISING, FALLING or STOP.
//   - On accept, latch cmd and go to ERASE.
//   - DRAW (111) and undefined codes are ignored, with no action taken.
// - frame_tick while busy is dropped, not queued. state_in changes after accept do not affect the update.
// - ERASE: scan BIRD_W*BIRD_H pixels, one per cycle.
//   - cx increments fastest (0..BIRD_W-1), then cy.
//   - x_out = X_POS+cx, y_out = bird_y+cy, colour = BG_COLOUR, plot = 1.
// - UPDATE: one cycle, plot = 0. bird_y is updated as follows:
//   - START or STOP: bird_y = Y_START; touched cleared.
//   - RAISING: bird_y = (bird_y >= RISE_STEP) ? bird_y-RISE_STEP : 0. Saturates at 0 and never wraps.
//   - FALLING: bird_y = min(bird_y+FALL_STEP, Y_MAX), computed in 8 bits to avoid overflow.
//   - If the result equals Y_MAX, touched is set. It is sticky until START, STOP or reset.
//   - flag is registered and updated in the same cycle: flag = (new bird_y < Y_MIN).
// - DRAW: the same scan as ERASE at the new bird_y, with colour = BIRD_COLOUR.
// - DONE: done = 1 for one cycle, then return to IDLE.
// - Timing, with accept at clock edge k (BIRD_W=BIRD_H=4):
//   - ERASE pixels on cycles k+1..k+16.
//   - UPDATE on k+17.
//   - DRAW pixels on k+18..k+33.
//   - done on k+34.
//   - busy = 1 on k+1..k+34.
//   - The next accept is possible at k+35.
// - plot is 1 only in ERASE and DRAW; x_out, y_out and colour are valid whenever plot = 1.
// TESTING
// - Reset, then release.
//   - Expect bird_y=56, busy=0, plot=0, flag=0, touched=0.
//   - No plot while frame_tick=0 for 100 cycles.
// - state_in=110 (RAISING), one tick at bird_y=56.
//   - 16 pixels with colour 000 at x 40..43, y 56..59.
//   - Then 16 pixels with colour 110 at y 54..57.
//   - done at k+34; bird_y=54.
// - state_in=011 (FALLING), 65 ticks from 56.
//   - bird_y reaches 116 on tick 60; touched=1 from then on.
//   - Ticks 61..65 keep bird_y=116.
//   - Then state_in=010 (START) + tick gives bird_y=56, touched=0.
// - RAISING ticks from bird_y=5.
//   - Expect bird_y 3 with flag=1, then 1, then 0, then 0 (saturation, no wrap).
//   - flag stays 1.
// - Ignore cases:
//   - state_in=111 with a tick in IDLE: no busy, no plot.
//   - A tick at k+10 during an update is ignored; exactly 32 plots occur and bird_y changes once.
// - resetn low at cycle k+20 (mid-DRAW).
//   - plot=0 and busy=0 immediately; bird_y=56.
//   - The next tick starts a clean 34-cycle update.

Source files
------------

// File: rtl/bird_datapath.sv
// Bird datapath: executes one controller command per frame tick, erasing the sprite,
// moving bird_y, redrawing it through the VGA pixel port and reporting flag/touched.
module bird_datapath #(
   parameter int         X_POS       = 40,
   parameter int         BIRD_W      = 4,
   parameter int         BIRD_H      = 4,
   parameter int         Y_START     = 56,
   parameter int         Y_MIN       = 4,
   parameter int         Y_MAX       = 116,
   parameter int         RISE_STEP   = 2,
   parameter int         FALL_STEP   = 1,
   parameter logic [2:0] BIRD_COLOUR = 3'b110,
   parameter logic [2:0] BG_COLOUR   = 3'b000
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic [2:0] state_in,
   input  logic       frame_tick,
   output logic [7:0] x_out,
   output logic [6:0] y_out,
   output logic [2:0] colour,
   output logic       plot,
   output logic       busy,
   output logic       done,
   output logic [6:0] bird_y,
   output logic       flag,
   output logic       touched
);

   localparam logic [2:0] CMD_START   = 3'b010;
   localparam logic [2:0] CMD_RAISING = 3'b110;
   localparam logic [2:0] CMD_FALLING = 3'b011;
   localparam logic [2:0] CMD_STOP    = 3'b001;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ERASE  = 3'd1,
      S_UPDATE = 3'd2,
      S_DRAW   = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t     state_r;
   state_t     state_s;
   logic [2:0] cmd_r;
   logic [7:0] cx_r;
   logic [6:0] cy_r;
   logic       cmd_ok_s;
   logic       accept_s;
   logic       scan_last_s;
   logic [7:0] y_sum_s;
   logic [6:0] y_new_s;

   // Only movement/reset commands start an update; DRAW and undefined codes are ignored.
   always_comb begin
      cmd_ok_s = 1'b0;
      case (state_in)
         CMD_START, CMD_RAISING, CMD_FALLING, CMD_STOP: cmd_ok_s = 1'b1;
         default:                                       cmd_ok_s = 1'b0;
      endcase
   end

   assign accept_s    = (state_r == S_IDLE) && frame_tick && cmd_ok_s;
   assign scan_last_s = (cx_r == 8'(BIRD_W - 1)) && (cy_r == 7'(BIRD_H - 1));

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (accept_s) state_s = S_ERASE;
            else          state_s = S_IDLE;
         end
         S_ERASE: begin
            if (scan_last_s) state_s = S_UPDATE;
            else             state_s = S_ERASE;
         end
         S_UPDATE: state_s = S_DRAW;
         S_DRAW: begin
            if (scan_last_s) state_s = S_DONE;
            else             state_s = S_DRAW;
         end
         S_DONE:  state_s = S_IDLE;
         default: state_s = S_IDLE;
      endcase
   end

   // New bird row; the fall sum is widened to 8 bits so it cannot wrap before clamping.
   always_comb begin
      y_sum_s = {1'b0, bird_y} + 8'(FALL_STEP);
      y_new_s = bird_y;
      case (cmd_r)
         CMD_RAISING: begin
            if (bird_y >= 7'(RISE_STEP)) y_new_s = bird_y - 7'(RISE_STEP);
            else                         y_new_s = 7'd0;
         end
         CMD_FALLING: begin
            if (y_sum_s >= 8'(Y_MAX)) y_new_s = 7'(Y_MAX);
            else                      y_new_s = y_sum_s[6:0];
         end
         default: y_new_s = 7'(Y_START);
      endcase
   end

   // Command latch and sprite scan counters (cx fastest, then cy).
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cmd_r <= 3'b000;
         cx_r  <= 8'd0;
         cy_r  <= 7'd0;
      end else begin
         if (accept_s) cmd_r <= state_in;
         else          cmd_r <= cmd_r;
         if ((state_r == S_ERASE) || (state_r == S_DRAW)) begin
            if (cx_r == 8'(BIRD_W - 1)) begin
               cx_r <= 8'd0;
               if (scan_last_s) cy_r <= 7'd0;
               else             cy_r <= cy_r + 7'd1;
            end else begin
               cx_r <= cx_r + 8'd1;
               cy_r <= cy_r;
            end
         end else begin
            cx_r <= 8'd0;
            cy_r <= 7'd0;
         end
      end
   end

   // Registered pixel port and handshake outputs, one cycle behind the scan state.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         x_out  <= 8'd0;
         y_out  <= 7'd0;
         colour <= 3'b000;
         plot   <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         busy <= (state_r != S_IDLE);
         done <= (state_r == S_DONE);
         case (state_r)
            S_ERASE, S_DRAW: begin
               plot   <= 1'b1;
               x_out  <= 8'(X_POS) + cx_r;
               y_out  <= bird_y + cy_r;
               colour <= (state_r == S_DRAW) ? BIRD_COLOUR : BG_COLOUR;
            end
            default: begin
               plot   <= 1'b0;
               x_out  <= 8'd0;
               y_out  <= 7'd0;
               colour <= 3'b000;
            end
         endcase
      end
   end

   // Bird position and status; touched stays set until START/STOP.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         bird_y  <= 7'(Y_START);
         flag    <= 1'b0;
         touched <= 1'b0;
      end else if (state_r == S_UPDATE) begin
         bird_y <= y_new_s;
         flag   <= (y_new_s < 7'(Y_MIN));
         if ((cmd_r == CMD_START) || (cmd_r == CMD_STOP)) touched <= 1'b0;
         else if (y_new_s == 7'(Y_MAX))                    touched <= 1'b1;
         else                                              touched <= touched;
      end else begin
         bird_y  <= bird_y;
         flag    <= flag;
         touched <= touched;
      end
   end

endmodule

// File: tb/tb_bird_datapath.sv
// Scoreboard bench for bird_datapath: stimulus pushes expected pixels and done records,
// an independent monitor pops and compares them whenever plot or done is raised.
module tb_bird_datapath;

   localparam logic [2:0] START   = 3'b010;
   localparam logic [2:0] RAISING = 3'b110;
   localparam logic [2:0] FALLING = 3'b011;
   localparam logic [2:0] STOP    = 3'b001;
   localparam logic [2:0] DRAWC   = 3'b111;

   logic       clk = 1'b0;
   logic       resetn;
   logic [2:0] state_in;
   logic       frame_tick;
   logic [7:0] x_out;
   logic [6:0] y_out;
   logic [2:0] colour;
   logic       plot, busy, done, flag, touched;
   logic [6:0] bird_y;

   typedef struct { int cyc; int x; int y; int c; } pix_t;
   typedef struct { int cyc; int y; int f; int t; } done_t;

   pix_t  pix_q[$];
   done_t done_q[$];

   int cyc = 0;
   int plots = 0;
   int checks = 0;
   int errors = 0;
   int m_y, m_f, m_t;

   bird_datapath dut (
      .clk(clk), .resetn(resetn), .state_in(state_in), .frame_tick(frame_tick),
      .x_out(x_out), .y_out(y_out), .colour(colour), .plot(plot), .busy(busy),
      .done(done), .bird_y(bird_y), .flag(flag), .touched(touched)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   task automatic model_update(input logic [2:0] cmd);
      case (cmd)
         RAISING: m_y = (m_y >= 2) ? m_y - 2 : 0;
         FALLING: m_y = (m_y + 1 >= 116) ? 116 : m_y + 1;
         default: begin m_y = 56; m_t = 0; end
      endcase
      if (m_y == 116) m_t = 1;
      m_f = (m_y < 4) ? 1 : 0;
   endtask

   task automatic push_update(input int k, input int oldy);
      pix_t  p;
      done_t d;
      for (int n = 0; n < 16; n++) begin
         p.cyc = k + 1 + n; p.x = 40 + n % 4; p.y = oldy + n / 4; p.c = 0;
         pix_q.push_back(p);
      end
      for (int n = 0; n < 16; n++) begin
         p.cyc = k + 18 + n; p.x = 40 + n % 4; p.y = m_y + n / 4; p.c = 6;
         pix_q.push_back(p);
      end
      d.cyc = k + 34; d.y = m_y; d.f = m_f; d.t = m_t;
      done_q.push_back(d);
   endtask

   // Issue one command tick; optionally raise a stray tick at offset extra into the update.
   task automatic run_cmd(input logic [2:0] cmd, input int extra);
      int k, oldy, bad, p0;
      logic exp_busy;
      @(negedge clk);
      state_in   = cmd;
      frame_tick = 1'b1;
      k    = cyc + 1;
      oldy = m_y;
      p0   = plots;
      model_update(cmd);
      push_update(k, oldy);
      bad = 0;
      for (int j = 0; j <= 35; j++) begin
         @(negedge clk);
         state_in   = DRAWC;
         frame_tick = (extra != 0 && j == extra - 1);
         exp_busy   = (j >= 1 && j <= 34);
         if (busy !== exp_busy) bad++;
      end
      frame_tick = 1'b0;
      check("busy_window", bad, 0);
      check("plot_count", plots - p0, 32);
   endtask

   // Monitor: every plot and done pulse must match the head of its queue.
   initial begin
      pix_t  p;
      done_t d;
      forever begin
         @(negedge clk);
         if (resetn === 1'b1 && plot === 1'b1) begin
            plots++;
            checks++;
            if (pix_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_plot: cyc=%0d x=%0d y=%0d c=%0d, want no plot", cyc, x_out, y_out, colour);
            end else begin
               p = pix_q.pop_front();
               if (cyc != p.cyc || int'(x_out) != p.x || int'(y_out) != p.y || int'(colour) != p.c) begin
                  errors++;
                  $display("FAIL pixel: got cyc=%0d x=%0d y=%0d c=%0d, want cyc=%0d x=%0d y=%0d c=%0d",
                           cyc, x_out, y_out, colour, p.cyc, p.x, p.y, p.c);
               end
            end
         end
         if (resetn === 1'b1 && done === 1'b1) begin
            checks++;
            if (done_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_done: cyc=%0d, want no done", cyc);
            end else begin
               d = done_q.pop_front();
               if (cyc != d.cyc || int'(bird_y) != d.y || int'(flag) != d.f || int'(touched) != d.t) begin
                  errors++;
                  $display("FAIL done: got cyc=%0d y=%0d flag=%0d touched=%0d, want cyc=%0d y=%0d flag=%0d touched=%0d",
                           cyc, bird_y, flag, touched, d.cyc, d.y, d.f, d.t);
               end
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, want $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, p0, bad;
      resetn = 1'b0; frame_tick = 1'b0; state_in = 3'b000;
      m_y = 56; m_f = 0; m_t = 0;
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      check("rst_bird_y", bird_y, 56);
      check("rst_busy", busy, 0);
      check("rst_plot", plot, 0);
      check("rst_done", done, 0);
      check("rst_flag", flag, 0);
      check("rst_touched", touched, 0);
      check("rst_pixel", {x_out, y_out, colour}, 0);

      p0 = plots;
      state_in = RAISING;
      repeat (100) @(negedge clk);
      check("idle_no_plot", plots - p0, 0);
      check("idle_busy", busy, 0);

      run_cmd(RAISING, 0);
      check("raise_y", bird_y, 54);
      run_cmd(START, 0);
      check("start_y", bird_y, 56);

      for (int i = 1; i <= 65; i++) begin
         run_cmd(FALLING, 0);
         if (i == 59) check("fall59_y", bird_y, 115);
         if (i == 59) check("fall59_touched", touched, 0);
         if (i == 60) check("fall60_y", bird_y, 116);
         if (i == 60) check("fall60_touched", touched, 1);
      end
      check("fall65_y", bird_y, 116);
      check("fall65_touched", touched, 1);
      run_cmd(START, 0);
      check("restart_y", bird_y, 56);
      check("restart_touched", touched, 0);

      run_cmd(FALLING, 0);
      for (int i = 0; i < 26; i++) run_cmd(RAISING, 0);
      check("at5_y", bird_y, 5);
      check("at5_flag", flag, 0);
      run_cmd(RAISING, 0);
      check("r3_y", bird_y, 3);
      check("r3_flag", flag, 1);
      run_cmd(RAISING, 0);
      check("r1_y", bird_y, 1);
      run_cmd(RAISING, 0);
      check("r0_y", bird_y, 0);
      run_cmd(RAISING, 0);
      check("sat_y", bird_y, 0);
      check("sat_flag", flag, 1);

      @(negedge clk);
      state_in = DRAWC; frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      p0 = plots; bad = 0;
      repeat (40) begin
         if (busy !== 1'b0) bad++;
         @(negedge clk);
      end
      check("draw_code_busy", bad, 0);
      check("draw_code_plots", plots - p0, 0);

      run_cmd(FALLING, 10);
      check("tick_busy_y", bird_y, 1);
      p0 = plots;
      repeat (40) @(negedge clk);
      check("tick_busy_no_replay", plots - p0, 0);
      check("tick_busy_y_hold", bird_y, 1);

      @(negedge clk);
      state_in = FALLING; frame_tick = 1'b1;
      k = cyc + 1;
      p0 = m_y;
      model_update(FALLING);
      push_update(k, p0);
      @(negedge clk);
      frame_tick = 1'b0;
      while (cyc < k + 20) @(negedge clk);
      #1 resetn = 1'b0;
      #1;
      check("abort_plot", plot, 0);
      check("abort_busy", busy, 0);
      check("abort_bird_y", bird_y, 56);
      pix_q.delete();
      done_q.delete();
      m_y = 56; m_f = 0; m_t = 0;
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      run_cmd(RAISING, 0);
      check("post_abort_y", bird_y, 54);

      repeat (5) @(negedge clk);
      check("pix_q_empty", pix_q.size(), 0);
      check("done_q_empty", done_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
